// File: rtl/starflux_pkg.sv
// starflux_pkg: shared playfield geometry, colour defaults and renderer state encoding.
// Used by shifter_grid and grid_renderer so both agree on grid size and pixel layout.
package starflux_pkg;

    localparam int DEF_GRID_W = 160;
    localparam int DEF_GRID_H = 120;

    localparam logic [2:0] DEF_BULLET_COLOUR = 3'b111;
    localparam logic [2:0] DEF_PLAYER_COLOUR = 3'b010;
    localparam logic [2:0] DEF_BG_COLOUR     = 3'b000;

    // VGA adapter coordinate widths
    localparam int X_W = 8;
    localparam int Y_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } render_state_t;

    // Pixel (x,y) lives at bit y*w+x of the flattened grid
    function automatic int pixel_index(input int x, input int y, input int w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// raster_counter: x-fastest raster position counter with wrap and last-pixel flag.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   clear          : force position to (0,0)
//   advance        : step to the next pixel in raster order
//   x, y           : current position
//   last           : high while the position is (GRID_W-1, GRID_H-1)
module raster_counter
    import starflux_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    logic x_end;

    assign x_end = x == X_W'(GRID_W - 1);
    assign last  = x_end && y == Y_W'(GRID_H - 1);

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            x <= x_end ? '0 : x + 1'b1;
            y <= last ? '0 : (x_end ? y + 1'b1 : y);
        end
    end

endmodule

// File: rtl/grid_renderer.sv
// grid_renderer: walks the playfield in raster order and emits one VGA pixel write per cycle.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   start          : request one frame (honoured only in IDLE)
//   grid           : flattened playfield, read live every cycle
//   user_x         : player column, captured when the frame starts
//   x_out, y_out   : pixel position to the VGA adapter
//   colour         : pixel colour
//   plot           : pixel write strobe
//   busy           : frame in progress (from first plot through the done cycle)
//   done           : one-cycle frame completion pulse
module grid_renderer
    import starflux_pkg::*;
#(
    parameter int         GRID_W        = DEF_GRID_W,
    parameter int         GRID_H        = DEF_GRID_H,
    parameter logic [2:0] BULLET_COLOUR = DEF_BULLET_COLOUR,
    parameter logic [2:0] PLAYER_COLOUR = DEF_PLAYER_COLOUR,
    parameter logic [2:0] BG_COLOUR     = DEF_BG_COLOUR
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [GRID_W*GRID_H-1:0]   grid,
    input  logic [7:0]                 user_x,
    output logic [7:0]                 x_out,
    output logic [6:0]                 y_out,
    output logic [2:0]                 colour,
    output logic                       plot,
    output logic                       busy,
    output logic                       done
);

    localparam int IDX_W = $clog2(GRID_W * GRID_H);

    render_state_t  state, state_d;
    logic [7:0]     user_q, user_d;
    logic [7:0]     x_d;
    logic [6:0]     y_d;
    logic [2:0]     colour_d;
    logic           plot_d, busy_d, done_d;
    logic           tail_q, tail_d;
    logic           clear, advance, last;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic [IDX_W-1:0] idx;
    logic [2:0]     pix;

    raster_counter #(
        .GRID_W(GRID_W),
        .GRID_H(GRID_H)
    ) u_raster (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (clear),
        .advance(advance),
        .x      (cx),
        .y      (cy),
        .last   (last)
    );

    // A latched column outside the grid never matches cx, so no player pixel appears
    assign idx = IDX_W'(pixel_index(int'(cx), int'(cy), GRID_W));
    assign pix = (cy == Y_W'(GRID_H - 1) && cx == user_q) ? PLAYER_COLOUR :
                 grid[idx] ? BULLET_COLOUR : BG_COLOUR;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            x_out  <= '0;
            y_out  <= '0;
            colour <= BG_COLOUR;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            user_q <= '0;
            tail_q <= 1'b0;
        end else begin
            state  <= state_d;
            x_out  <= x_d;
            y_out  <= y_d;
            colour <= colour_d;
            plot   <= plot_d;
            busy   <= busy_d;
            done   <= done_d;
            user_q <= user_d;
            tail_q <= tail_d;
        end
    end

    // DRAW spans the setup cycle plus every plot cycle; tail_q marks that the
    // final pixel has been registered, so the following edge raises done.
    // DONE then lasts one cycle, which makes start in that cycle fall on a
    // non-IDLE state and get dropped.
    always_comb begin
        state_d  = state;
        x_d      = x_out;
        y_d      = y_out;
        colour_d = colour;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        user_d   = user_q;
        tail_d   = 1'b0;
        clear    = 1'b0;
        advance  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = DRAW;
                    clear   = 1'b1;
                    user_d  = user_x;
                end
            end
            DRAW: begin
                busy_d = 1'b1;
                if (tail_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    x_d      = cx;
                    y_d      = cy;
                    colour_d = pix;
                    plot_d   = 1'b1;
                    advance  = 1'b1;
                    tail_d   = last;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: randomized self-checking bench for grid_renderer against a pixel-rule model.
module tb_grid_renderer;

    localparam int         W   = 160;
    localparam int         H   = 120;
    localparam int         N   = W * H;
    localparam logic [2:0] BUL = 3'b111;
    localparam logic [2:0] PLY = 3'b010;
    localparam logic [2:0] BGC = 3'b000;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] grid = '0;
    logic [7:0]   user_x = '0;
    logic [7:0]   x_out;
    logic [6:0]   y_out;
    logic [2:0]   colour;
    logic         plot, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_x = 0;
    int last_y = 0;

    always #10 clock = ~clock;

    grid_renderer #(
        .GRID_W(W),
        .GRID_H(H),
        .BULLET_COLOUR(BUL),
        .PLAYER_COLOUR(PLY),
        .BG_COLOUR(BGC)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (start),
        .grid   (grid),
        .user_x (user_x),
        .x_out  (x_out),
        .y_out  (y_out),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Player beats bullet, bullet beats background
    function automatic logic [2:0] ref_colour(input int x, input int y, input int ux, input logic b);
        if (y == H - 1 && x == ux) return PLY;
        if (b) return BUL;
        return BGC;
    endfunction

    task automatic fill_grid(input int force_bit);
        for (int i = 0; i < N; i++) grid[i] = ($urandom_range(0, 3) == 0);
        if (force_bit >= 0) grid[force_bit] = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, 32'({plot, busy, done}), 32'(3'b000));
        check({tag, "_pos"}, 32'({x_out, y_out}), 32'({8'(last_x), 7'(last_y)}));
    endtask

    // Cycle c is the interval after the c-th rising edge counted from the start edge
    task automatic run_frame(input logic [7:0] ux, input int ux_at, input logic [7:0] ux_new,
                             input int r1, input int r2, input int period,
                             input int force_bit, input int abort_at);
        int ex, ey;
        logic [2:0] ec;
        user_x = ux;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cyc = 0;
        start = 1'b0;
        check_idle("setup");
        for (int c = 1; c <= N + 4; c++) begin
            @(posedge clock);
            @(negedge clock);
            cyc = c;
            if (c == abort_at) begin
                check("rst_ctl", 32'({plot, busy, done}), 32'(3'b000));
                check("rst_pos", 32'({x_out, y_out}), 32'(0));
                last_x = 0;
                last_y = 0;
                reset_n = 1'b1;
                return;
            end
            if (c <= N) begin
                ex = (c - 1) % W;
                ey = (c - 1) / W;
                ec = ref_colour(ex, ey, int'(ux), grid[ey * W + ex]);
                check("pix_ctl", 32'({plot, busy, done}), 32'(3'b110));
                check("pix_pos", 32'({x_out, y_out}), 32'({8'(ex), 7'(ey)}));
                check("pix_col", 32'(colour), 32'(ec));
                last_x = ex;
                last_y = ey;
            end else if (c == N + 1) begin
                check("done_ctl", 32'({plot, busy, done}), 32'(3'b011));
            end else begin
                check_idle("post");
            end
            if (c == ux_at) user_x = ux_new;
            start = (c + 1 == r1) || (c + 1 == r2);
            if (period > 0 && c % period == 0) fill_grid(force_bit);
            if (c + 1 == abort_at) reset_n = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_ctl", 32'({plot, busy, done}), 32'(3'b000));
        check("reset_pos", 32'({x_out, y_out}), 32'(0));
        check("reset_col", 32'(colour), 32'(BGC));
        start = 1'b0;
        reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_idle("idle");

        // empty grid, player at 5, user_x moved mid-frame, start re-pulsed mid-frame and in done cycle
        grid = '0;
        run_frame(8'd5, 100, 8'd7, 50, N + 1, 0, -1, 0);

        // random grid with first and last bits set, player off-grid
        fill_grid(-1);
        grid[0] = 1'b1;
        grid[N - 1] = 1'b1;
        run_frame(8'd200, 0, 8'd0, 0, 0, 0, -1, 0);

        // player over a set bit, aborted by reset, then a full frame with live grid updates
        fill_grid((H - 1) * W + 10);
        run_frame(8'd10, 0, 8'd0, 0, 0, 0, -1, 1000);
        run_frame(8'd10, 0, 8'd0, 0, 0, 4096, (H - 1) * W + 10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grid_renderer.md
GRID_RENDERER -- requirements
Module: grid_renderer

Interface
REQ-001 Parameter GRID_W, default 160, grid width in pixels.
REQ-002 Parameter GRID_H, default 120, grid height in pixels.
REQ-003 Parameter BULLET_COLOUR, default 3'b111, colour of a set grid bit.
REQ-004 Parameter PLAYER_COLOUR, default 3'b010, colour of the player pixel.
REQ-005 Parameter BG_COLOUR, default 3'b000, colour of a clear grid bit.
REQ-006 clock  in  1  system clock (50 MHz); all state updates on its rising edge.
REQ-007 reset_n  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  one-cycle request to render one frame.
REQ-009 grid  in  GRID_W*GRID_H  flattened playfield; pixel (x,y) is bit y*GRID_W+x.
REQ-010 user_x  in  8  player column.
REQ-011 x_out  out  8  pixel column to the VGA adapter.
REQ-012 y_out  out  7  pixel row to the VGA adapter.
REQ-013 colour  out  3  pixel colour.
REQ-014 plot  out  1  high when x_out/y_out/colour form a valid pixel write.
REQ-015 busy  out  1  high while a frame is in progress; the upstream shifter SHALL NOT be advanced while busy is high.
REQ-016 done  out  1  one-cycle pulse marking frame completion.

Function
REQ-017 States: IDLE, DRAW, DONE; state register and all outputs are registered.
REQ-018 IDLE: start=1 -> DRAW on the next edge; raster counters set to (0,0); user_x latched into an internal register.
REQ-019 DRAW: one pixel per cycle, raster order, x fastest; x wraps GRID_W-1 -> 0 with y incremented.
REQ-020 Latency: pixel (x,y) is presented on the outputs in cycle 1+y*GRID_W+x after the start edge; plot is high for exactly GRID_W*GRID_H consecutive cycles (19200 at default parameters).
REQ-021 Colour priority: y==GRID_H-1 and x==latched user_x -> PLAYER_COLOUR; else grid bit set -> BULLET_COLOUR; else BG_COLOUR.
REQ-022 Latched user_x >= GRID_W -> no player pixel is drawn; all pixels follow grid content.
REQ-023 After pixel (GRID_W-1,GRID_H-1): -> DONE; plot=0, done=1 for one cycle; then -> IDLE.
REQ-024 busy is high from the first plot cycle through the done cycle inclusive, and low in IDLE.
REQ-025 start while busy (DRAW or DONE) is ignored; no queuing.
REQ-026 start in the same cycle that DONE returns to IDLE is ignored; start is accepted only when the state is IDLE.
REQ-027 The grid input is read live each cycle; user_x changes during DRAW have no effect.
REQ-028 In IDLE: plot=0, done=0, busy=0, and x_out/y_out hold their last values.

Reset
REQ-029 reset_n=0 at a clock edge: state=IDLE, x_out=0, y_out=0, colour=BG_COLOUR, plot=0, busy=0, done=0, latched user_x=0.
REQ-030 Reset takes priority over start and over any in-progress frame; a frame aborted mid-DRAW produces no done pulse.

Structure
REQ-031 GRID_W, GRID_H, the colour constants, and the state encodings SHALL live in the shared starflux package, used by both shifter_grid and grid_renderer.
REQ-032 The raster x/y counter with wrap and last-pixel flag SHALL be a sub-module named raster_counter; the FSM and colour select remain in grid_renderer.

Verification
REQ-033 Empty grid, user_x=5, start pulse -> 19200 plot cycles; all pixels BG except (5,119)=3'b010; done at cycle 19201; busy low at cycle 19202.
REQ-034 grid bit 0 and bit 19199 set, user_x=200 -> (0,0)=3'b111 at cycle 1; (159,119)=3'b111 at cycle 19200; no player pixel.
REQ-035 Bit (10,119) set, user_x=10 -> pixel (10,119)=3'b010 (player wins).
REQ-036 start re-pulsed at cycles 50 and 19201 -> single frame only; done pulses once; busy never drops mid-frame.
REQ-037 reset_n low at cycle 1000 -> next cycle plot=0, busy=0, x_out=0, y_out=0, no done; a new start then renders from (0,0).
REQ-038 user_x changed from 5 to 7 at cycle 100 -> player pixel still drawn at (5,119).
